sa_wresp_merge_channel: RTL and testbench

- Write-response channel of the slave-side arbiter. Successor to the crossing-filter WRESP path.
- Accepts B responses from one slave port and routes them to MST_AMT dispatcher ports.
- Generalises the 4KB-crossing split from exactly 2 sub-transactions to 1..SPLIT_MAX.
- Merges all sub-responses of one master transaction into a single B beat with worst-case BRESP, instead of dropping the first.

---
 rtl/sa_wresp_merge_channel.sv | 186 ++++++++++++++++++
 tb/tb_sa_wresp_merge_channel.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_wresp_merge_channel.sv
// Write-response merge channel: orders B beats by AW issue, merges split sub-responses
// into one worst-case B beat per master transaction. Optional ID check: WRESP_ID_CHECK_EN.
module sa_wresp_merge_channel #(
  parameter int unsigned MST_AMT         = 3,
  parameter int unsigned OUTSTANDING_AMT = 8,
  parameter int unsigned MST_ID_W        = $clog2(MST_AMT),
  parameter int unsigned TRANS_MST_ID_W  = 5,
  parameter int unsigned TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
  parameter int unsigned TRANS_WR_RESP_W = 2,
  parameter int unsigned SPLIT_MAX       = 4,
  parameter int unsigned SPLIT_CNT_W     = $clog2(SPLIT_MAX + 1)
) (
  input  logic                                 ACLK_i,
  input  logic                                 ARESET_i,
  input  logic [TRANS_SLV_ID_W-1:0]            AW_AxID_i,
  input  logic [SPLIT_CNT_W-1:0]               AW_split_cnt_i,
  input  logic                                 AW_shift_en_i,
  output logic                                 AW_stall_o,
  input  logic [TRANS_SLV_ID_W-1:0]            s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]           s_BRESP_i,
  input  logic                                 s_BVALID_i,
  output logic                                 s_BREADY_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_BID_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]   dsp_BRESP_o,
  output logic [MST_AMT-1:0]                   dsp_BVALID_o,
  input  logic [MST_AMT-1:0]                   dsp_BREADY_i,
  output logic                                 err_o
);

  localparam int unsigned PTR_W = $clog2(OUTSTANDING_AMT);
  localparam int unsigned CNT_W = $clog2(OUTSTANDING_AMT + 1);

  typedef struct packed {
    logic [TRANS_SLV_ID_W-1:0] id;
    logic [SPLIT_CNT_W-1:0]    split;
  } order_t;

  typedef enum logic {ST_ACCUM, ST_DELIVER} state_e;

  order_t                      mem_q [OUTSTANDING_AMT];
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        stall_q;
  logic [SPLIT_CNT_W-1:0]      sub_q, sub_d;
  logic [TRANS_WR_RESP_W-1:0]  acc_q, acc_d;
  state_e                      state_q, state_d;
  logic [MST_AMT-1:0]          bvalid_q, bvalid_d;
  logic [TRANS_MST_ID_W-1:0]   bid_q, bid_d;
  logic [TRANS_WR_RESP_W-1:0]  bresp_q, bresp_d;
  logic [MST_ID_W-1:0]         mst_q, mst_d;

  order_t                      head;
  logic [SPLIT_CNT_W-1:0]      head_split;
  logic [MST_ID_W-1:0]         head_mst;
  logic                        head_mst_ok, head_final, out_free;
  logic                        push, pop, s_hs;
  logic [TRANS_WR_RESP_W-1:0]  merged;

  // Head entry decode; a split count of 0 means a single sub-transaction.
  always_comb begin
    head = mem_q[rd_ptr_q];
    if (head.split == '0)
      head_split = SPLIT_CNT_W'(1);
    else if (head.split > SPLIT_CNT_W'(SPLIT_MAX))
      head_split = SPLIT_CNT_W'(SPLIT_MAX);
    else
      head_split = head.split;
  end

  assign head_mst    = head.id[TRANS_SLV_ID_W-1 -: MST_ID_W];
  assign head_mst_ok = {1'b0, head_mst} < (MST_ID_W+1)'(MST_AMT);
  assign head_final  = (sub_q + SPLIT_CNT_W'(1)) == head_split;
  assign out_free    = (state_q == ST_ACCUM) || dsp_BREADY_i[mst_q];

  // Only a deliverable final beat can be held off by the output register.
  assign s_BREADY_o = (cnt_q != '0) && !(head_final && head_mst_ok && !out_free);
  assign s_hs       = s_BVALID_i && s_BREADY_o;
  assign pop        = s_hs && head_final;
  assign push       = AW_shift_en_i && (cnt_q != CNT_W'(OUTSTANDING_AMT));

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Merge / deliver next-state logic.
  always_comb begin
    state_d  = state_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    mst_d    = mst_q;
    sub_d    = sub_q;
    acc_d    = acc_q;
    merged   = (s_BRESP_i > acc_q) ? s_BRESP_i : acc_q;

    if (state_q == ST_DELIVER && dsp_BREADY_i[mst_q]) begin
      state_d  = ST_ACCUM;
      bvalid_d = '0;
    end

    if (s_hs) begin
      if (head_final) begin
        sub_d = '0;
        acc_d = '0;
        if (head_mst_ok) begin
          state_d  = ST_DELIVER;
          bvalid_d = MST_AMT'(1) << head_mst;
          bid_d    = head.id[TRANS_MST_ID_W-1:0];
          mst_d    = head_mst;
          // EXOKAY cannot be guaranteed across split sub-transactions.
          if (merged == TRANS_WR_RESP_W'(1) && head_split > SPLIT_CNT_W'(1))
            bresp_d = '0;
          else
            bresp_d = merged;
        end
      end else begin
        sub_d = sub_q + SPLIT_CNT_W'(1);
        acc_d = merged;
      end
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      sub_q    <= '0;
      acc_q    <= '0;
      state_q  <= ST_ACCUM;
      bvalid_q <= '0;
      bid_q    <= '0;
      bresp_q  <= '0;
      mst_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q    <= cnt_d;
      stall_q  <= (cnt_d == CNT_W'(OUTSTANDING_AMT));
      sub_q    <= sub_d;
      acc_q    <= acc_d;
      state_q  <= state_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      mst_q    <= mst_d;
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (push) mem_q[wr_ptr_q] <= {AW_AxID_i, AW_split_cnt_i};
  end

`ifdef WRESP_ID_CHECK_EN
  logic err_q, err_d;

  // Sticky: slave BID disagrees with the ordered head, or head targets no master.
  always_comb begin
    err_d = err_q;
    if (s_hs && ((s_BID_i != head.id) || !head_mst_ok)) err_d = 1'b1;
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_bid;
  assign unused_bid = ^s_BID_i;
  assign err_o      = 1'b0;
`endif

  assign AW_stall_o   = stall_q;
  assign dsp_BVALID_o = bvalid_q;
  assign dsp_BID_o    = {MST_AMT{bid_q}};
  assign dsp_BRESP_o  = {MST_AMT{bresp_q}};

endmodule

// File: tb/tb_sa_wresp_merge_channel.sv
// Bench for sa_wresp_merge_channel: directed scenarios plus randomized traffic against
// a transaction-level scoreboard.
module tb_sa_wresp_merge_channel;

  localparam int unsigned MST_AMT  = 3;
  localparam int unsigned MST_ID_W = 2;
  localparam int unsigned TID_W    = 5;
  localparam int unsigned SID_W    = 7;
  localparam int unsigned RW       = 2;
  localparam int unsigned SC_W     = 3;
  localparam int unsigned DEPTH    = 8;

  logic                      clk;
  logic                      ARESET_i;
  logic [SID_W-1:0]          AW_AxID_i;
  logic [SC_W-1:0]           AW_split_cnt_i;
  logic                      AW_shift_en_i;
  logic                      AW_stall_o;
  logic [SID_W-1:0]          s_BID_i;
  logic [RW-1:0]             s_BRESP_i;
  logic                      s_BVALID_i;
  logic                      s_BREADY_o;
  logic [TID_W*MST_AMT-1:0]  dsp_BID_o;
  logic [RW*MST_AMT-1:0]     dsp_BRESP_o;
  logic [MST_AMT-1:0]        dsp_BVALID_o;
  logic [MST_AMT-1:0]        dsp_BREADY_i;
  logic                      err_o;

  int n_pass, n_total;

  sa_wresp_merge_channel dut (
    .ACLK_i(clk), .ARESET_i(ARESET_i),
    .AW_AxID_i(AW_AxID_i), .AW_split_cnt_i(AW_split_cnt_i),
    .AW_shift_en_i(AW_shift_en_i), .AW_stall_o(AW_stall_o),
    .s_BID_i(s_BID_i), .s_BRESP_i(s_BRESP_i), .s_BVALID_i(s_BVALID_i),
    .s_BREADY_o(s_BREADY_o),
    .dsp_BID_o(dsp_BID_o), .dsp_BRESP_o(dsp_BRESP_o),
    .dsp_BVALID_o(dsp_BVALID_o), .dsp_BREADY_i(dsp_BREADY_i),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ARESET_i       = 1'b1;
    AW_AxID_i      = '0;
    AW_split_cnt_i = '0;
    AW_shift_en_i  = 1'b0;
    s_BID_i        = '0;
    s_BRESP_i      = '0;
    s_BVALID_i     = 1'b0;
    dsp_BREADY_i   = '1;
    tick();
    tick();
    ARESET_i = 1'b0;
  endtask

  task automatic push_aw(input logic [SID_W-1:0] id, input logic [SC_W-1:0] sc);
    AW_AxID_i      = id;
    AW_split_cnt_i = sc;
    AW_shift_en_i  = 1'b1;
    tick();
    AW_shift_en_i  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (dsp_BVALID_o !== '0) $display("FAIL reset_bvalid got=%b exp=0", dsp_BVALID_o); else n_pass++;
    n_total++; if (dsp_BID_o !== '0) $display("FAIL reset_bid got=%h exp=0", dsp_BID_o); else n_pass++;
    n_total++; if (dsp_BRESP_o !== '0) $display("FAIL reset_bresp got=%h exp=0", dsp_BRESP_o); else n_pass++;
    n_total++; if (AW_stall_o !== 1'b0) $display("FAIL reset_stall got=%b exp=0", AW_stall_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_o); else n_pass++;
    n_total++; if (s_BREADY_o !== 1'b0) $display("FAIL reset_bready got=%b exp=0", s_BREADY_o); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    // AW push and slave B presented together: the B must wait a cycle.
    AW_AxID_i = 7'h25; AW_split_cnt_i = 3'd1; AW_shift_en_i = 1'b1;
    s_BVALID_i = 1'b1; s_BID_i = 7'h25; s_BRESP_i = 2'd0;
    #1;
    n_total++; if (s_BREADY_o !== 1'b0) $display("FAIL single_bready_same_cycle got=%b exp=0", s_BREADY_o); else n_pass++;
    tick();
    AW_shift_en_i = 1'b0;
    #1;
    n_total++; if (s_BREADY_o !== 1'b1) $display("FAIL single_bready got=%b exp=1", s_BREADY_o); else n_pass++;
    tick();
    s_BVALID_i = 1'b0;
    n_total++; if (dsp_BVALID_o !== 3'b010) $display("FAIL single_bvalid got=%b exp=010", dsp_BVALID_o); else n_pass++;
    n_total++; if (dsp_BID_o !== {3{5'h05}}) $display("FAIL single_bid got=%h exp=%h", dsp_BID_o, {3{5'h05}}); else n_pass++;
    n_total++; if (dsp_BRESP_o !== 6'd0) $display("FAIL single_bresp got=%h exp=0", dsp_BRESP_o); else n_pass++;
    n_total++; if (AW_stall_o !== 1'b0) $display("FAIL single_stall got=%b exp=0", AW_stall_o); else n_pass++;
    tick();
    n_total++; if (dsp_BVALID_o !== '0) $display("FAIL single_bvalid_clear got=%b exp=0", dsp_BVALID_o); else n_pass++;
  endtask

  task automatic test_split3();
    logic [1:0] resps [3];
    resps[0] = 2'd0; resps[1] = 2'd2; resps[2] = 2'd0;
    do_reset();
    push_aw(7'h05, 3'd3);
    for (int k = 0; k < 3; k++) begin
      s_BVALID_i = 1'b1; s_BID_i = 7'h05; s_BRESP_i = resps[k];
      #1;
      n_total++; if (s_BREADY_o !== 1'b1) $display("FAIL split3_bready k=%0d got=%b exp=1", k, s_BREADY_o); else n_pass++;
      tick();
      n_total++;
      if (dsp_BVALID_o !== ((k == 2) ? 3'b001 : 3'b000))
        $display("FAIL split3_bvalid k=%0d got=%b exp=%b", k, dsp_BVALID_o, (k == 2) ? 3'b001 : 3'b000);
      else n_pass++;
    end
    s_BVALID_i = 1'b0;
    n_total++; if (dsp_BRESP_o !== {3{2'd2}}) $display("FAIL split3_bresp got=%h exp=%h", dsp_BRESP_o, {3{2'd2}}); else n_pass++;
    n_total++; if (dsp_BID_o !== {3{5'h05}}) $display("FAIL split3_bid got=%h exp=%h", dsp_BID_o, {3{5'h05}}); else n_pass++;
    tick();
    n_total++; if (dsp_BVALID_o !== '0) $display("FAIL split3_one_beat got=%b exp=0", dsp_BVALID_o); else n_pass++;
  endtask

  task automatic test_exokay();
    do_reset();
    push_aw(7'h43, 3'd2);
    push_aw(7'h44, 3'd1);
    s_BVALID_i = 1'b1; s_BID_i = 7'h43; s_BRESP_i = 2'd1;
    tick();
    tick();
    s_BID_i = 7'h44; s_BRESP_i = 2'd1;
    n_total++; if (dsp_BVALID_o !== 3'b100) $display("FAIL exok_split2_bvalid got=%b exp=100", dsp_BVALID_o); else n_pass++;
    n_total++; if (dsp_BRESP_o !== 6'd0) $display("FAIL exok_split2_bresp got=%h exp=0", dsp_BRESP_o); else n_pass++;
    tick();
    s_BVALID_i = 1'b0;
    n_total++; if (dsp_BID_o !== {3{5'h04}}) $display("FAIL exok_split1_bid got=%h exp=%h", dsp_BID_o, {3{5'h04}}); else n_pass++;
    n_total++; if (dsp_BRESP_o !== {3{2'd1}}) $display("FAIL exok_split1_bresp got=%h exp=%h", dsp_BRESP_o, {3{2'd1}}); else n_pass++;
    tick();
  endtask

  task automatic test_full();
    int sent, seen;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (AW_stall_o !== 1'b0) $display("FAIL full_stall_before i=%0d got=%b exp=0", i, AW_stall_o); else n_pass++;
      push_aw(7'(i), 3'd1);
    end
    n_total++; if (AW_stall_o !== 1'b1) $display("FAIL full_stall_at8 got=%b exp=1", AW_stall_o); else n_pass++;
    push_aw(7'h08, 3'd1);
    n_total++; if (AW_stall_o !== 1'b1) $display("FAIL full_stall_after9 got=%b exp=1", AW_stall_o); else n_pass++;
    // Pop while full: the concurrent push is blocked, so occupancy drops to 7.
    AW_AxID_i = 7'h09; AW_split_cnt_i = 3'd1; AW_shift_en_i = 1'b1;
    s_BVALID_i = 1'b1; s_BID_i = 7'h00; s_BRESP_i = 2'd0;
    tick();
    AW_shift_en_i = 1'b0;
    sent = 1; seen = 0;
    n_total++; if (AW_stall_o !== 1'b0) $display("FAIL full_stall_after_pop got=%b exp=0", AW_stall_o); else n_pass++;
    for (int c = 0; c < 14; c++) begin
      if (dsp_BVALID_o[0]) begin
        n_total++;
        if (dsp_BID_o[TID_W-1:0] !== 5'(seen)) $display("FAIL full_order got=%h exp=%h", dsp_BID_o[TID_W-1:0], 5'(seen)); else n_pass++;
        seen++;
      end
      s_BVALID_i = 1'b1;
      s_BID_i    = 7'(sent);
      #1;
      if (s_BREADY_o) sent++;
      tick();
    end
    n_total++; if (seen !== 8) $display("FAIL full_beat_count got=%0d exp=8", seen); else n_pass++;
    n_total++; if (s_BREADY_o !== 1'b0) $display("FAIL full_empty_bready got=%b exp=0", s_BREADY_o); else n_pass++;
    s_BVALID_i = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    dsp_BREADY_i = 3'b101;
    push_aw(7'h21, 3'd1);
    push_aw(7'h22, 3'd1);
    push_aw(7'h23, 3'd1);
    s_BVALID_i = 1'b1; s_BID_i = 7'h21; s_BRESP_i = 2'd1;
    tick();
    s_BID_i = 7'h22; s_BRESP_i = 2'd2;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++; if (dsp_BVALID_o !== 3'b010) $display("FAIL bp_bvalid c=%0d got=%b exp=010", c, dsp_BVALID_o); else n_pass++;
      n_total++; if (dsp_BID_o !== {3{5'h01}}) $display("FAIL bp_bid c=%0d got=%h exp=%h", c, dsp_BID_o, {3{5'h01}}); else n_pass++;
      n_total++; if (dsp_BRESP_o !== {3{2'd1}}) $display("FAIL bp_bresp c=%0d got=%h exp=%h", c, dsp_BRESP_o, {3{2'd1}}); else n_pass++;
      n_total++; if (s_BREADY_o !== 1'b0) $display("FAIL bp_bready c=%0d got=%b exp=0", c, s_BREADY_o); else n_pass++;
      tick();
    end
    dsp_BREADY_i = 3'b111;
    #1;
    n_total++; if (s_BREADY_o !== 1'b1) $display("FAIL bp_release_bready got=%b exp=1", s_BREADY_o); else n_pass++;
    tick();
    s_BID_i = 7'h23; s_BRESP_i = 2'd3;
    n_total++; if (dsp_BID_o !== {3{5'h02}} || dsp_BRESP_o !== {3{2'd2}})
      $display("FAIL bp_second got=%h/%h exp=%h/%h", dsp_BID_o, dsp_BRESP_o, {3{5'h02}}, {3{2'd2}}); else n_pass++;
    tick();
    s_BVALID_i = 1'b0;
    n_total++; if (dsp_BVALID_o !== 3'b010 || dsp_BID_o !== {3{5'h03}} || dsp_BRESP_o !== {3{2'd3}})
      $display("FAIL bp_third got=%b/%h/%h exp=010/%h/%h", dsp_BVALID_o, dsp_BID_o, dsp_BRESP_o, {3{5'h03}}, {3{2'd3}}); else n_pass++;
    tick();
  endtask

  task automatic test_id_check();
    logic exp_err;
`ifdef WRESP_ID_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    push_aw(7'h05, 3'd1);
    s_BVALID_i = 1'b1; s_BID_i = 7'h06; s_BRESP_i = 2'd0;
    tick();
    s_BVALID_i = 1'b0;
    n_total++; if (err_o !== exp_err) $display("FAIL idchk_err got=%b exp=%b", err_o, exp_err); else n_pass++;
    n_total++; if (dsp_BVALID_o !== 3'b001 || dsp_BID_o !== {3{5'h05}})
      $display("FAIL idchk_fifo_id got=%b/%h exp=001/%h", dsp_BVALID_o, dsp_BID_o, {3{5'h05}}); else n_pass++;
    tick(); tick(); tick();
    n_total++; if (err_o !== exp_err) $display("FAIL idchk_err_sticky got=%b exp=%b", err_o, exp_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int wait_c;
    do_reset();
    dsp_BREADY_i = '0;
    push_aw(7'h25, 3'd1);
    push_aw(7'h05, 3'd3);
    s_BVALID_i = 1'b1; s_BID_i = 7'h25; s_BRESP_i = 2'd0;
    tick();
    s_BID_i = 7'h05; s_BRESP_i = 2'd3;
    tick();
    s_BVALID_i = 1'b0;
    ARESET_i = 1'b1;
    tick();
    n_total++; if (dsp_BVALID_o !== '0 || dsp_BID_o !== '0 || dsp_BRESP_o !== '0)
      $display("FAIL midrst_outputs got=%b/%h/%h exp=0/0/0", dsp_BVALID_o, dsp_BID_o, dsp_BRESP_o); else n_pass++;
    n_total++; if (s_BREADY_o !== 1'b0 || AW_stall_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL midrst_ctrl got=%b/%b/%b exp=0/0/0", s_BREADY_o, AW_stall_o, err_o); else n_pass++;
    ARESET_i = 1'b0;
    dsp_BREADY_i = '1;
    push_aw(7'h25, 3'd1);
    s_BVALID_i = 1'b1; s_BID_i = 7'h25; s_BRESP_i = 2'd0;
    wait_c = 0;
    while (dsp_BVALID_o == '0 && wait_c < 20) begin
      tick();
      s_BVALID_i = 1'b0;
      wait_c++;
    end
    n_total++; if (wait_c !== 1) $display("FAIL midrst_latency got=%0d exp=1", wait_c); else n_pass++;
    n_total++; if (dsp_BVALID_o !== 3'b010 || dsp_BRESP_o !== 6'd0)
      $display("FAIL midrst_clean got=%b/%h exp=010/0", dsp_BVALID_o, dsp_BRESP_o); else n_pass++;
    tick();
  endtask

  typedef struct {
    logic [SID_W-1:0] id;
    logic [RW-1:0]    resp;
    bit               fin;
  } beat_t;

  typedef struct {
    logic [MST_ID_W-1:0] mst;
    logic [TID_W-1:0]    bid;
    logic [RW-1:0]       resp;
  } exp_t;

  task automatic test_random();
    beat_t sq[$];
    exp_t  eq[$];
    beat_t b;
    exp_t  e;
    int    model_cnt, aw_done, cyc, nsplit, r;
    bit    push_acc, hs_out, prev_hold, any_drop, s_hs;
    logic [MST_AMT-1:0]       prev_v;
    logic [TID_W*MST_AMT-1:0] prev_bid;
    logic [RW*MST_AMT-1:0]    prev_resp;
    logic [SID_W-1:0] nid;
    logic [SC_W-1:0]  nsc;
    logic [RW-1:0]    worst;
    logic [RW-1:0]    sub_r [4];
    logic             exp_err;

    do_reset();
    model_cnt = 0; aw_done = 0; cyc = 0;
    prev_hold = 1'b0; any_drop = 1'b0;
    while (cyc < 6000 && !(aw_done == 60 && sq.size() == 0 && eq.size() == 0)) begin
      cyc++;
      n_total++;
      if (AW_stall_o !== (model_cnt == DEPTH)) $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, AW_stall_o, model_cnt == DEPTH); else n_pass++;
      if (prev_hold) begin
        n_total++;
        if (dsp_BVALID_o !== prev_v || dsp_BID_o !== prev_bid || dsp_BRESP_o !== prev_resp)
          $display("FAIL rnd_hold cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, dsp_BVALID_o, dsp_BID_o, dsp_BRESP_o, prev_v, prev_bid, prev_resp);
        else n_pass++;
      end
      dsp_BREADY_i = MST_AMT'($urandom);
      hs_out = |(dsp_BVALID_o & dsp_BREADY_i);
      if (hs_out) begin
        n_total++;
        if (eq.size() == 0) $display("FAIL rnd_extra_beat got=%b exp=none", dsp_BVALID_o);
        else begin
          e = eq.pop_front();
          if (dsp_BVALID_o !== (MST_AMT'(1) << e.mst) || dsp_BID_o !== {MST_AMT{e.bid}} || dsp_BRESP_o !== {MST_AMT{e.resp}})
            $display("FAIL rnd_beat got=%b/%h/%h exp=%b/%h/%h", dsp_BVALID_o, dsp_BID_o, dsp_BRESP_o,
                     MST_AMT'(1) << e.mst, {MST_AMT{e.bid}}, {MST_AMT{e.resp}});
          else n_pass++;
        end
      end
      prev_hold = (dsp_BVALID_o != '0) && !hs_out;
      prev_v = dsp_BVALID_o; prev_bid = dsp_BID_o; prev_resp = dsp_BRESP_o;

      push_acc = 1'b0;
      AW_shift_en_i = 1'b0;
      if (aw_done < 60 && $urandom_range(0, 9) < 4) begin
        r   = $urandom_range(0, 9);
        nid = {((r == 9) ? 2'd3 : 2'(r % 3)), 5'($urandom)};
        nsc = 3'($urandom_range(0, 4));
        AW_AxID_i = nid; AW_split_cnt_i = nsc; AW_shift_en_i = 1'b1;
        push_acc = (model_cnt < DEPTH);
      end
      if (sq.size() != 0 && $urandom_range(0, 9) < 7) begin
        s_BVALID_i = 1'b1; s_BID_i = sq[0].id; s_BRESP_i = sq[0].resp;
      end else begin
        s_BVALID_i = 1'b0; s_BID_i = 7'($urandom); s_BRESP_i = 2'($urandom);
      end
      #1;
      s_hs = s_BVALID_i && s_BREADY_o;
      if (s_hs) begin
        b = sq.pop_front();
        if (b.fin) model_cnt--;
      end
      if (push_acc) begin
        nsplit = (nsc == 0) ? 1 : int'(nsc);
        worst = 2'd0;
        for (int k = 0; k < nsplit; k++) begin
          sub_r[k] = 2'($urandom);
          if (sub_r[k] > worst) worst = sub_r[k];
          b.id = nid; b.resp = sub_r[k]; b.fin = (k == nsplit - 1);
          sq.push_back(b);
        end
        if (worst == 2'd1 && nsplit > 1) worst = 2'd0;
        if (nid[6:5] == 2'd3) any_drop = 1'b1;
        else begin
          e.mst = nid[6:5]; e.bid = nid[4:0]; e.resp = worst;
          eq.push_back(e);
        end
        model_cnt++;
        aw_done++;
      end
      tick();
    end
    AW_shift_en_i = 1'b0;
    s_BVALID_i = 1'b0;
    n_total++;
    if (cyc >= 6000) $display("FAIL rnd_timeout aw=%0d pending_b=%0d pending_out=%0d exp=0", aw_done, sq.size(), eq.size()); else n_pass++;
`ifdef WRESP_ID_CHECK_EN
    exp_err = any_drop;
`else
    exp_err = 1'b0;
`endif
    n_total++; if (err_o !== exp_err) $display("FAIL rnd_err got=%b exp=%b", err_o, exp_err); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_single();
    test_split3();
    test_exokay();
    test_full();
    test_backpressure();
    test_id_check();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
